// File: rtl/cr_kme_ib_dbg_mux.sv
// KME inbound stream merge: packet-boundary arbitration between functional and debug beats,
// feeding a 2-entry registered output buffer. CR_KME_IB_DBG_CNT_EN enables the debug beat counter.
module cr_kme_ib_dbg_mux #(
  parameter int DATA_W  = 64,
  parameter int TID_W   = 1,
  parameter int TSTRB_W = 8,
  parameter int USER_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               func_tvalid,
  input  logic               func_tlast,
  input  logic [TID_W-1:0]   func_tid,
  input  logic [TSTRB_W-1:0] func_tstrb,
  input  logic [USER_W-1:0]  func_tuser,
  input  logic [DATA_W-1:0]  func_tdata,
  output logic               func_tready,

  input  logic               dbg_tvalid,
  input  logic               dbg_tlast,
  input  logic [TID_W-1:0]   dbg_tid,
  input  logic [TSTRB_W-1:0] dbg_tstrb,
  input  logic [USER_W-1:0]  dbg_tuser,
  input  logic [DATA_W-1:0]  dbg_tdata,
  output logic               dbg_tready,

  output logic               out_tvalid,
  output logic               out_tlast,
  output logic [TID_W-1:0]   out_tid,
  output logic [TSTRB_W-1:0] out_tstrb,
  output logic [USER_W-1:0]  out_tuser,
  output logic [DATA_W-1:0]  out_tdata,
  input  logic               out_tready,

  output logic               dbg_active,
  output logic [15:0]        dbg_beat_cnt
);

  localparam int PAY_W = 1 + TID_W + TSTRB_W + USER_W + DATA_W;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_FUNC = 2'd1,
    ARB_DBG  = 2'd2
  } arb_e;

  arb_e             state_q, state_d;
  logic [1:0]       cnt_q;
  logic             rd_ptr_q, wr_ptr_q;
  logic [PAY_W-1:0] mem_q [2];

  logic             buf_ok;
  logic             grant_func, grant_dbg;
  logic             func_acc, dbg_acc;
  logic             push, pop;
  logic [PAY_W-1:0] push_data;

  // buf_ok depends only on registered occupancy, keeping out_tready off the input ready paths
  assign buf_ok = (cnt_q != 2'd2);

  always_comb begin
    grant_func = 1'b0;
    grant_dbg  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (dbg_tvalid)       grant_dbg  = 1'b1;
        else if (func_tvalid) grant_func = 1'b1;
      end
      ARB_FUNC: grant_func = func_tvalid;
      ARB_DBG:  grant_dbg  = dbg_tvalid;
      default: begin
        grant_func = 1'b0;
        grant_dbg  = 1'b0;
      end
    endcase
  end

  assign func_tready = buf_ok & grant_func;
  assign dbg_tready  = buf_ok & grant_dbg;
  assign func_acc    = func_tready & func_tvalid;
  assign dbg_acc     = dbg_tready & dbg_tvalid;

  always_comb begin
    state_d = state_q;
    if (dbg_acc)       state_d = dbg_tlast  ? ARB_IDLE : ARB_DBG;
    else if (func_acc) state_d = func_tlast ? ARB_IDLE : ARB_FUNC;
    else if (state_q != ARB_IDLE && state_q != ARB_FUNC && state_q != ARB_DBG)
      state_d = ARB_IDLE;
  end

  assign push      = func_acc | dbg_acc;
  assign pop       = (cnt_q != 2'd0) & out_tready;
  assign push_data = dbg_acc ? {dbg_tlast, dbg_tid, dbg_tstrb, dbg_tuser, dbg_tdata}
                             : {func_tlast, func_tid, func_tstrb, func_tuser, func_tdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign {out_tlast, out_tid, out_tstrb, out_tuser, out_tdata} = mem_q[rd_ptr_q];
  assign out_tvalid = (cnt_q != 2'd0);
  assign dbg_active = (state_q == ARB_DBG);

`ifdef CR_KME_IB_DBG_CNT_EN
  logic [15:0] dbg_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                dbg_cnt_q <= 16'h0000;
    else if (dbg_acc && dbg_cnt_q != 16'hFFFF) dbg_cnt_q <= dbg_cnt_q + 16'd1;
  end

  assign dbg_beat_cnt = dbg_cnt_q;
`else
  assign dbg_beat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cr_kme_ib_dbg_mux.sv
// Directed self-checking bench for cr_kme_ib_dbg_mux; counter checks follow CR_KME_IB_DBG_CNT_EN.
module tb_cr_kme_ib_dbg_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        func_tvalid, func_tlast, func_tready;
  logic [0:0]  func_tid;
  logic [7:0]  func_tstrb, func_tuser;
  logic [63:0] func_tdata;
  logic        dbg_tvalid, dbg_tlast, dbg_tready;
  logic [0:0]  dbg_tid;
  logic [7:0]  dbg_tstrb, dbg_tuser;
  logic [63:0] dbg_tdata;
  logic        out_tvalid, out_tlast, out_tready;
  logic [0:0]  out_tid;
  logic [7:0]  out_tstrb, out_tuser;
  logic [63:0] out_tdata;
  logic        dbg_active;
  logic [15:0] dbg_beat_cnt;

  int checks   = 0;
  int failures = 0;

  cr_kme_ib_dbg_mux dut (
    .clk(clk), .rst_n(rst_n),
    .func_tvalid(func_tvalid), .func_tlast(func_tlast), .func_tid(func_tid),
    .func_tstrb(func_tstrb), .func_tuser(func_tuser), .func_tdata(func_tdata),
    .func_tready(func_tready),
    .dbg_tvalid(dbg_tvalid), .dbg_tlast(dbg_tlast), .dbg_tid(dbg_tid),
    .dbg_tstrb(dbg_tstrb), .dbg_tuser(dbg_tuser), .dbg_tdata(dbg_tdata),
    .dbg_tready(dbg_tready),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tid(out_tid),
    .out_tstrb(out_tstrb), .out_tuser(out_tuser), .out_tdata(out_tdata),
    .out_tready(out_tready),
    .dbg_active(dbg_active), .dbg_beat_cnt(dbg_beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] got_data[$];
  logic        got_last[$];
  int          k;
  logic [15:0] exp_cnt;

  initial begin
    rst_n = 1'b0;
    func_tvalid = 0; func_tlast = 0; func_tid = 0; func_tstrb = 8'hFF; func_tuser = 0; func_tdata = 0;
    dbg_tvalid = 0;  dbg_tlast = 0;  dbg_tid = 1;  dbg_tstrb = 8'hFF;  dbg_tuser = 8'h5A; dbg_tdata = 0;
    out_tready = 1'b1;
    #12;
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tdata", out_tdata, 0);
    chk("rst_out_tlast", out_tlast, 0);
    chk("rst_out_tuser", out_tuser, 0);
    chk("rst_func_tready", func_tready, 0);
    chk("rst_dbg_tready", dbg_tready, 0);
    chk("rst_dbg_active", dbg_active, 0);
    chk("rst_dbg_beat_cnt", dbg_beat_cnt, 0);
    #11 rst_n = 1'b1;
    tick();

    // functional 4-beat packet
    for (int i = 0; i < 4; i++) begin
      func_tvalid = 1; func_tdata = 64'h100 + 64'(i); func_tlast = (i == 3); func_tuser = 8'(i);
      #1;
      chk("f4_func_tready", func_tready, 1);
      chk("f4_dbg_tready", dbg_tready, 0);
      tick();
      chk("f4_out_tvalid", out_tvalid, 1);
      chk("f4_out_tdata", out_tdata, 64'h100 + 64'(i));
      chk("f4_out_tlast", out_tlast, (i == 3));
      chk("f4_out_tuser", out_tuser, 64'(i));
    end
    func_tvalid = 0; func_tlast = 0;
    tick();
    chk("f4_drained", out_tvalid, 0);

    // debug beat raised mid functional packet
    for (int i = 0; i < 3; i++) begin
      func_tvalid = 1; func_tdata = 64'h300 + 64'(i); func_tlast = (i == 2);
      if (i == 1) begin
        dbg_tvalid = 1; dbg_tlast = 1; dbg_tdata = 64'hDEAD_BEEF_0123_4567;
      end
      #1;
      chk("mid_func_tready", func_tready, 1);
      chk("mid_dbg_held", dbg_tready, 0);
      tick();
      chk("mid_out_tdata", out_tdata, 64'h300 + 64'(i));
    end
    func_tvalid = 0; func_tlast = 0;
    #1;
    chk("mid_dbg_tready", dbg_tready, 1);
    tick();
    chk("mid_dbg_out_tdata", out_tdata, 64'hDEAD_BEEF_0123_4567);
    chk("mid_dbg_out_tlast", out_tlast, 1);
    chk("mid_dbg_out_tuser", out_tuser, 64'h5A);
    chk("mid_dbg_out_tid", out_tid, 1);
    dbg_tvalid = 0;
    #1;
    chk("mid_dbg_pulse_end", dbg_tready, 0);
    tick();
    chk("mid_drained", out_tvalid, 0);

    // simultaneous request in idle: debug first
    func_tvalid = 1; func_tlast = 1; func_tdata = 64'hAAAA;
    dbg_tvalid = 1;  dbg_tlast = 1;  dbg_tdata = 64'hBBBB;
    #1;
    chk("both_dbg_tready", dbg_tready, 1);
    chk("both_func_tready", func_tready, 0);
    tick();
    chk("both_first_out", out_tdata, 64'hBBBB);
    dbg_tvalid = 0;
    #1;
    chk("both_func_next", func_tready, 1);
    tick();
    chk("both_second_out", out_tdata, 64'hAAAA);
    chk("both_second_valid", out_tvalid, 1);
    func_tvalid = 0; func_tlast = 0;
    tick();

    // back-pressure: out_tready low for 5 cycles
    k = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_tready  = !(cyc >= 1 && cyc <= 5);
      func_tvalid = (k < 8);
      func_tdata  = 64'h200 + 64'(k);
      func_tlast  = (k == 7);
      #1;
      if (cyc >= 2 && cyc <= 5) chk("bp_func_tready_low", func_tready, 0);
      if (cyc >= 7 && cyc <= 12) chk("bp_func_tready_high", func_tready, 1);
      if (cyc >= 7 && cyc <= 13) chk("bp_out_tvalid", out_tvalid, 1);
      if (out_tvalid && out_tready) begin
        got_data.push_back(out_tdata);
        got_last.push_back(out_tlast);
      end
      if (func_tvalid && func_tready) k++;
      tick();
    end
    func_tvalid = 0; func_tlast = 0; out_tready = 1;
    chk("bp_beat_count", 64'(got_data.size()), 8);
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      chk("bp_order", got_data[i], 64'h200 + 64'(i));
      chk("bp_tlast", 64'(got_last[i]), (i == 7));
    end

    // debug packet open with a gap
    dbg_tvalid = 1; dbg_tlast = 0; dbg_tdata = 64'hC0C0;
    #1;
    chk("gap_dbg_tready", dbg_tready, 1);
    tick();
    chk("gap_first_out", out_tdata, 64'hC0C0);
    dbg_tvalid = 0;
    func_tvalid = 1; func_tlast = 1; func_tdata = 64'hF00D;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("gap_dbg_active", dbg_active, 1);
      chk("gap_func_blocked", func_tready, 0);
      tick();
    end
    dbg_tvalid = 1; dbg_tlast = 1; dbg_tdata = 64'hD0D0;
    #1;
    chk("gap_close_dbg_tready", dbg_tready, 1);
    chk("gap_close_func_tready", func_tready, 0);
    tick();
    chk("gap_close_out", out_tdata, 64'hD0D0);
    chk("gap_idle", dbg_active, 0);
    dbg_tvalid = 0;
    #1;
    chk("gap_func_resume", func_tready, 1);
    tick();
    chk("gap_func_out", out_tdata, 64'hF00D);
    func_tvalid = 0; func_tlast = 0;
    tick();

    // counter saturation and mid-packet reset
`ifdef CR_KME_IB_DBG_CNT_EN
    chk("cnt_after_4", dbg_beat_cnt, 4);
    force dut.dbg_cnt_q = 16'hFFFE;
    #1;
    release dut.dbg_cnt_q;
    exp_cnt = 16'hFFFF;
`else
    chk("cnt_tied_zero", dbg_beat_cnt, 0);
    exp_cnt = 16'h0000;
`endif
    for (int i = 0; i < 3; i++) begin
      dbg_tvalid = 1; dbg_tlast = 0; dbg_tdata = 64'hE000 + 64'(i);
      #1;
      chk("sat_dbg_tready", dbg_tready, 1);
      tick();
    end
    dbg_tvalid = 0;
    chk("sat_cnt", dbg_beat_cnt, 64'(exp_cnt));
    chk("sat_dbg_active", dbg_active, 1);
    chk("sat_out_tdata", out_tdata, 64'hE002);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_tvalid", out_tvalid, 0);
    chk("mrst_out_tdata", out_tdata, 0);
    chk("mrst_dbg_active", dbg_active, 0);
    chk("mrst_dbg_beat_cnt", dbg_beat_cnt, 0);
    chk("mrst_dbg_tready", dbg_tready, 0);
    tick();
    rst_n = 1'b1;
    func_tvalid = 1; func_tlast = 1; func_tdata = 64'h7777;
    #1;
    chk("post_rst_func_tready", func_tready, 1);
    tick();
    chk("post_rst_out", out_tdata, 64'h7777);
    func_tvalid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
